cache_fill_arbiter: RTL

Miss-handling controller that shares the single off-chip memory port between the I-cache and the D-cache. It arbitrates pending misses and sequences the 8-word (16-byte) block fill into the 2-way, 64-set cache data and metadata arrays. It also forwards write-through stores to memory when no fill is in progress. It sits between both cache instances and the multi-cycle memory model, and it drives the pipeline stall lines.

---
 rtl/cache_ctrl_pkg.sv | 16 +
 rtl/fill_word_counter.sv | 38 +++
 rtl/cache_fill_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and geometry for the cache miss/fill controller.
// Blocks are 16 bytes (8 x 16-bit words) in a 2-way, 64-set cache.
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_FILL = 2'd1,
        I_FILL = 2'd2
    } fill_state_t;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int OFFSET_W        = 4;
    localparam int TAG_W           = 6;
    localparam int SET_W           = 6;

endpackage

// File: rtl/fill_word_counter.sv
// Word counter for block fills: clear has priority over enable, and
// term_o flags when the count equals TERMINAL.
module fill_word_counter #(
    parameter int WIDTH    = 3,
    parameter int TERMINAL = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             term_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares the memory port between I- and D-cache misses, sequences 8-word
// block fills into the selected cache and forwards write-through stores.
module cache_fill_arbiter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_wr,
    input  logic [15:0]       dcache_wdata,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_data,
    input  logic              mem_data_valid,
    output logic              fill_wr_i,
    output logic              fill_wr_d,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [15:0]       fill_data,
    output logic              meta_wr_i,
    output logic              meta_wr_d,
    output logic              stall_i,
    output logic              stall_d
);

    import cache_ctrl_pkg::fill_state_t;
    import cache_ctrl_pkg::IDLE;
    import cache_ctrl_pkg::D_FILL;
    import cache_ctrl_pkg::I_FILL;
    import cache_ctrl_pkg::OFFSET_W;

    localparam int IDX_W  = $clog2(WORDS_PER_BLOCK);
    localparam int BASE_W = ADDR_W - OFFSET_W;

    fill_state_t       state_q;
    logic [BASE_W-1:0] base_q;

    logic [IDX_W:0]    issue_cnt;
    logic              issue_done;
    logic [IDX_W-1:0]  ret_cnt;
    logic              ret_last;

    logic in_fill;
    logic ret_beat;
    logic fill_done;

    assign in_fill   = (state_q != IDLE);
    assign ret_beat  = in_fill & mem_data_valid;
    assign fill_done = ret_beat & ret_last;

    // Issue side stops at WORDS_PER_BLOCK so a slow memory never sees a ninth read.
    fill_word_counter #(
        .WIDTH   (IDX_W + 1),
        .TERMINAL(WORDS_PER_BLOCK)
    ) u_issue_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (fill_done),
        .en_i   (in_fill & ~issue_done),
        .count_o(issue_cnt),
        .term_o (issue_done)
    );

    fill_word_counter #(
        .WIDTH   (IDX_W),
        .TERMINAL(WORDS_PER_BLOCK - 1)
    ) u_ret_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (fill_done),
        .en_i   (ret_beat),
        .count_o(ret_cnt),
        .term_o (ret_last)
    );

    // D-side misses win ties; the losing I miss simply stays asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dcache_miss) begin
                        state_q <= D_FILL;
                        base_q  <= dcache_addr[ADDR_W-1:OFFSET_W];
                    end else if (icache_miss) begin
                        state_q <= I_FILL;
                        base_q  <= icache_addr[ADDR_W-1:OFFSET_W];
                    end
                end
                D_FILL, I_FILL: begin
                    if (fill_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (state_q == IDLE) begin
            if (dcache_wr && !dcache_miss) begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = dcache_addr;
                mem_wdata  = dcache_wdata;
            end
        end else if (!issue_done) begin
            mem_enable = 1'b1;
            mem_addr   = {base_q, issue_cnt[IDX_W-1:0], 1'b0};
        end
    end

    assign fill_wr_d = ret_beat & (state_q == D_FILL);
    assign fill_wr_i = ret_beat & (state_q == I_FILL);
    assign fill_addr = ret_beat ? {base_q, ret_cnt, 1'b0} : '0;
    assign fill_data = mem_data;
    assign meta_wr_d = fill_done & (state_q == D_FILL);
    assign meta_wr_i = fill_done & (state_q == I_FILL);

    // A store during any fill must wait, since the memory port is busy.
    assign stall_d = dcache_miss | (in_fill & dcache_wr);
    assign stall_i = icache_miss;

    logic unused_icache_offset;
    assign unused_icache_offset = ^icache_addr[OFFSET_W-1:0];

endmodule
